// File: rtl/iomem_gpio.sv
// GPIO peripheral on the picosoc iomem bus: 32-bit output register, debounced
// switch inputs with per-bit change interrupts, and a registered level irq.
module iomem_gpio #(
    parameter logic [7:0] ADDR_HI         = 8'h03,
    parameter int         DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        irq
);

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic        sel;
    logic [1:0]  reg_idx;
    logic [31:0] rd_mux;
    logic [7:0]  w1c;
    logic [31:0] gpio_out;
    logic [7:0]  irq_status;
    logic [7:0]  irq_en;
    logic [7:0]  sw_p0;
    logic [7:0]  sw_p1;
    logic [7:0]  deb;
    logic [7:0]  deb_flip;
    logic [15:0] cnt [0:7];
    logic        unused_addr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        return res;
    endfunction

    // Ready blocks re-selection, so at most one transaction every two cycles.
    assign sel         = iomem_valid & ~iomem_ready & (iomem_addr[31:24] == ADDR_HI);
    assign reg_idx     = iomem_addr[3:2];
    assign w1c         = (sel && reg_idx == 2'd2 && iomem_wstrb[0]) ? iomem_wdata[7:0] : 8'h00;
    assign led         = gpio_out[7:0];
    assign unused_addr = ^{iomem_addr[23:4], iomem_addr[1:0]};

    always_comb begin
        rd_mux = 32'h0;
        case (reg_idx)
            2'd0: rd_mux = gpio_out;
            2'd1: rd_mux = {24'h0, deb};
            2'd2: rd_mux = {24'h0, irq_status};
            2'd3: rd_mux = {24'h0, irq_en};
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        deb_flip = 8'h00;
        for (int i = 0; i < 8; i++)
            deb_flip[i] = (sw_p1[i] != deb[i]) && (cnt[i] == CNT_MAX);
    end

    // Bus stage: read data captures the pre-write value on the same edge as the write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            gpio_out    <= 32'h0;
            irq_en      <= 8'h00;
        end else begin
            iomem_ready <= sel;
            if (sel) begin
                iomem_rdata <= rd_mux;
                if (reg_idx == 2'd0)
                    gpio_out <= merge_bytes(gpio_out, iomem_wdata, iomem_wstrb);
                if (reg_idx == 2'd3 && iomem_wstrb[0])
                    irq_en <= iomem_wdata[7:0];
            end
        end
    end

    // Synchronizer (sw_p0 -> sw_p1) then per-bit stability counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_p0 <= 8'h00;
            sw_p1 <= 8'h00;
            deb   <= 8'h00;
            for (int i = 0; i < 8; i++) cnt[i] <= 16'h0;
        end else begin
            sw_p0 <= sw;
            sw_p1 <= sw_p0;
            for (int i = 0; i < 8; i++) begin
                if (sw_p1[i] == deb[i]) begin
                    cnt[i] <= 16'h0;
                end else if (deb_flip[i]) begin
                    deb[i] <= sw_p1[i];
                    cnt[i] <= 16'h0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    // A debounced change sets status on the same edge; a coincident clear loses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_status <= 8'h00;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~w1c) | deb_flip;
            irq        <= |(irq_status & irq_en);
        end
    end

endmodule

// File: tb/tb_iomem_gpio.sv
// Directed bench for iomem_gpio with DEBOUNCE_CYCLES=4: expected read data is
// queued at issue time and a negedge monitor checks it on every ready pulse.
module tb_iomem_gpio;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic [7:0]  sw = 8'h00;
    logic [7:0]  led;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    localparam logic [31:0] A_GPIO = 32'h0300_0000;
    localparam logic [31:0] A_SW   = 32'h0300_0004;
    localparam logic [31:0] A_STAT = 32'h0300_0008;
    localparam logic [31:0] A_EN   = 32'h0300_000C;

    iomem_gpio #(.ADDR_HI(8'h03), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .sw(sw), .led(led), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (iomem_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: got rdata 0x%08h expected no ready", iomem_rdata);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string n = name_q.pop_front();
                if (iomem_rdata !== e) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", n, iomem_rdata, e);
                end
            end
        end
    end

    // Issue one transaction; returns at the negedge while ready is high.
    task automatic xfer(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp);
        @(negedge clk);
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        iomem_valid = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_ready", {31'h0, iomem_ready}, 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Byte-lane writes and read-back
        xfer("wr_a5", A_GPIO, 32'h0000_00A5, 4'b0001, 32'h0);
        check("led_a5", {24'h0, led}, 32'h0000_00A5);
        xfer("rd_a5", A_GPIO, 32'h0, 4'b0000, 32'h0000_00A5);
        xfer("wr_zero", A_GPIO, 32'h0, 4'b1111, 32'h0000_00A5);
        xfer("wr_dead", A_GPIO, 32'hDEAD_BEEF, 4'b1010, 32'h0);
        xfer("rd_dead", A_GPIO, 32'h0, 4'b0000, 32'hDE00_BE00);
        check("led_00", {24'h0, led}, 32'h0);
        @(negedge clk);
        check("rdata_hold", iomem_rdata, 32'hDE00_BE00);
        xfer("wr_sw_ro", A_SW, 32'hFFFF_FFFF, 4'b1111, 32'h0);
        xfer("rd_sw_ro", A_SW, 32'h0, 4'b0000, 32'h0);

        // Enable irq for bit 3; upper/low address bits are aliased
        xfer("wr_en", A_EN, 32'h0000_0008, 4'b0001, 32'h0);
        xfer("rd_en_alias", 32'h03FF_FF0C, 32'h0, 4'b0000, 32'h0000_0008);

        // sw[3] rises: status sets 6 edges later, irq one edge after that
        sw = 8'h08;
        repeat (6) @(negedge clk);
        check("irq_early", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("irq_set", {31'h0, irq}, 32'h1);
        xfer("rd_sw_08", A_SW, 32'h0, 4'b0000, 32'h0000_0008);
        xfer("rd_stat_08", A_STAT, 32'h0, 4'b0000, 32'h0000_0008);

        // 3-cycle glitch on sw[0] must be rejected
        sw = 8'h09;
        repeat (3) @(negedge clk);
        sw = 8'h08;
        repeat (10) @(negedge clk);
        xfer("rd_sw_glitch", A_SW, 32'h0, 4'b0000, 32'h0000_0008);
        xfer("rd_stat_glitch", A_STAT, 32'h0, 4'b0000, 32'h0000_0008);

        // W1C drops irq one cycle after status clears
        xfer("w1c_stat", A_STAT, 32'h0000_0008, 4'b0001, 32'h0000_0008);
        check("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("irq_drop", {31'h0, irq}, 32'h0);
        xfer("rd_stat_clr", A_STAT, 32'h0, 4'b0000, 32'h0);

        // W1C on the same edge sw[3] debounces back to 0: set wins
        sw = 8'h00;
        repeat (4) @(negedge clk);
        xfer("w1c_race", A_STAT, 32'h0000_0008, 4'b0001, 32'h0);
        xfer("rd_stat_race", A_STAT, 32'h0, 4'b0000, 32'h0000_0008);
        xfer("rd_sw_00", A_SW, 32'h0, 4'b0000, 32'h0);
        check("irq_race", {31'h0, irq}, 32'h1);

        // Foreign address: no ready, no state change
        @(negedge clk);
        iomem_addr  = 32'h0200_0000;
        iomem_wdata = 32'hFFFF_FFFF;
        iomem_wstrb = 4'b1111;
        iomem_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("foreign_ready", {31'h0, iomem_ready}, 32'h0);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        xfer("rd_after_foreign", A_GPIO, 32'h0, 4'b0000, 32'hDE00_BE00);

        // Reset mid-transaction with valid held; sw[0] high through reset
        sw = 8'h01;
        @(negedge clk);
        iomem_addr  = A_GPIO;
        iomem_wdata = 32'h1234_5678;
        iomem_wstrb = 4'b1111;
        iomem_valid = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("rst2_ready", {31'h0, iomem_ready}, 32'h0);
        check("rst2_rdata", iomem_rdata, 32'h0);
        check("rst2_led", {24'h0, led}, 32'h0);
        check("rst2_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst2_no_ready", {31'h0, iomem_ready}, 32'h0);
        end
        xfer("rd_gpio_rst", A_GPIO, 32'h0, 4'b0000, 32'h0);
        xfer("rd_en_rst", A_EN, 32'h0, 4'b0000, 32'h0);
        repeat (6) @(negedge clk);
        xfer("rd_sw_boot", A_SW, 32'h0, 4'b0000, 32'h0000_0001);
        xfer("rd_stat_boot", A_STAT, 32'h0, 4'b0000, 32'h0000_0001);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iomem_gpio.md
IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 Parameter ADDR_HI, default 8'h03: iomem_addr[31:24] value that selects this peripheral.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: stable cycles required before a switch change is accepted (1 ms at 50 MHz); legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 iomem_valid  input  1  bus request from picosoc_noflash.
REQ-006 iomem_ready  output  1  one-cycle completion pulse.
REQ-007 iomem_wstrb  input  4  byte write enables; 4'b0000 = read.
REQ-008 iomem_addr  input  32  byte address.
REQ-009 iomem_wdata  input  32  write data.
REQ-010 iomem_rdata  output  32  read data, valid while iomem_ready=1.
REQ-011 sw  input  8  asynchronous switch inputs.
REQ-012 led  output  8  LED drive = GPIO_OUT[7:0].
REQ-013 irq  output  1  level interrupt = |(IRQ_STATUS & IRQ_EN), registered.

Function
REQ-014 Select = iomem_valid & !iomem_ready & (iomem_addr[31:24]==ADDR_HI); register picked by iomem_addr[3:2]; other address bits ignored.
REQ-015 On select, iomem_ready SHALL be 1 on the next cycle for exactly one cycle, then 0; no ready for non-matching addresses.
REQ-016 Map: 0 GPIO_OUT (32b RW); 1 SW_IN (RO, {24'b0, debounced sw}); 2 IRQ_STATUS (RO [7:0], write-1-to-clear); 3 IRQ_EN (RW [7:0]); unused bits read 0.
REQ-017 Writes apply per byte lane where iomem_wstrb[n]=1, on the same edge that raises iomem_ready; writes to SW_IN ignored.
REQ-018 iomem_rdata SHALL return the register value before the write of the same transaction; it holds its value when ready=0.
REQ-019 Each sw bit passes a 2-flop synchronizer (sync value s[i]) before any other use.
REQ-020 Per bit, a 16-bit counter: cleared when s[i]==deb[i]; else increments; when it equals DEBOUNCE_CYCLES-1 with mismatch still present, deb[i]<=s[i] and counter clears.
REQ-021 Resulting latency: deb[i] changes exactly DEBOUNCE_CYCLES cycles after s[i] first differs, provided s[i] stays stable; any glitch back restarts the count.
REQ-022 IRQ_STATUS[i] sets on the edge where deb[i] changes (either direction).
REQ-023 Simultaneous W1C and new set of the same bit: set wins.
REQ-024 irq updates one cycle after IRQ_STATUS/IRQ_EN change; clearing all enabled status bits drops irq one cycle later.
REQ-025 Back-to-back requests: a second select is evaluated only once iomem_ready has returned to 0 (maximum one transaction every 2 cycles).

Reset
REQ-026 resetn=0 SHALL immediately clear: iomem_ready, iomem_rdata, GPIO_OUT (so led=0), IRQ_STATUS, IRQ_EN, irq, synchronizers, deb, all counters.
REQ-027 Reset mid-transaction aborts it: no ready pulse after release, no partial write retained.
REQ-028 Switches held high through reset produce deb=1 and IRQ_STATUS set DEBOUNCE_CYCLES+2 cycles after release (intended: boot-time state report).

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Write 0x0300_0000 wdata 0x0000_00A5 wstrb 4'b0001 -> ready one cycle later, led=8'hA5; read back -> rdata 0x0000_00A5.
REQ-030 Write GPIO_OUT 0xDEADBEEF wstrb 4'b1010 from 0 -> read returns 0xDE00BE00, led=8'h00.
REQ-031 sw[3] 0->1 held -> SW_IN reads 0x08 and IRQ_STATUS[3]=1 exactly 2+4 cycles after change; with IRQ_EN=0x08, irq=1 one cycle later.
REQ-032 sw[0] pulses high for 3 cycles then low -> SW_IN stays 0, IRQ_STATUS stays 0.
REQ-033 Write IRQ_STATUS 0x08 on the same edge sw[3] debounces back to 0 -> IRQ_STATUS[3] remains 1.
REQ-034 Access to 0x0200_0000 -> no ready, no state change; resetn pulsed low with valid held -> all outputs 0, no ready until a new select after release.
